serial_frame_tx: RTL

Parallel-to-serial frame transmitter that drives the serial input of the 4-bit universal shift register stage on the board.
- Accepts a NBITS_DATA word through a valid/ready handshake.
- Emits one framed word: start bit, data LSB first, optional even parity, stop bit. Idle line is high.
- LSB-first order means that after NBITS_DATA right-shifts, the downstream shift register holds the word in its original bit order.
- Top-level mapping: clk_2, reset_n from a switch, data_in from SWI, serial_out/busy to LED.

---
 rtl/serial_frame_tx_if.sv | 17 +
 rtl/serial_frame_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx_if
// Brief    : Word handshake between a producer and serial_frame_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_frame_tx_if #(
   parameter int NBITS_DATA = 4
);
   logic [NBITS_DATA-1:0] data_in;
   logic                  valid;
   logic                  ready;

   modport master (output data_in, output valid, input ready);
   modport slave  (input data_in, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Brief    : Framed LSB-first serial transmitter (start, data, even parity, stop).
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
   parameter int NBITS_DATA = 4,
   parameter int BIT_CYCLES = 1,
   parameter int PARITY_EN  = 1
) (
   input  wire              clk_2,
   input  wire              reset_n,
   serial_frame_tx_if.slave tx_if,
   output logic             serial_out,
   output logic             busy,
   output logic             frame_done,
   output logic [3:0]       bit_index
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic [7:0] C_LAST_CYC = 8'(BIT_CYCLES - 1);
   localparam logic [3:0] C_LAST_BIT = 4'(NBITS_DATA - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_cnt;
   logic [7:0]            w_cnt_nxt;
   logic [3:0]            r_idx;
   logic [3:0]            w_idx_nxt;
   logic [NBITS_DATA-1:0] r_word;
   logic                  w_load;
   logic                  r_serial;
   logic                  w_serial_nxt;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  w_last;
   logic                  w_ready;
   logic                  w_parity;
   logic [NBITS_DATA-1:0] w_word_sh;

   assign w_last    = (r_cnt == C_LAST_CYC);
   assign w_ready   = (r_state == S_IDLE);
   assign w_parity  = ^r_word;
   // Bit that goes on the line when the data index advances by one.
   assign w_word_sh = r_word >> (r_idx + 4'd1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = w_last ? 8'd0 : (r_cnt + 8'd1);
      w_idx_nxt    = r_idx;
      w_serial_nxt = r_serial;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt    = 8'd0;
            w_idx_nxt    = 4'd0;
            w_serial_nxt = 1'b1;
            if (tx_if.valid) begin
               w_state_nxt  = S_START;
               w_serial_nxt = 1'b0;
               w_load       = 1'b1;
            end
         end
         S_START: begin
            if (w_last) begin
               w_state_nxt  = S_DATA;
               w_idx_nxt    = 4'd0;
               w_serial_nxt = r_word[0];
            end
         end
         S_DATA: begin
            if (w_last) begin
               if (r_idx == C_LAST_BIT) begin
                  w_idx_nxt = 4'd0;
                  if (PARITY_EN != 0) begin
                     w_state_nxt  = S_PARITY;
                     w_serial_nxt = w_parity;
                  end else begin
                     w_state_nxt  = S_STOP;
                     w_serial_nxt = 1'b1;
                  end
               end else begin
                  w_idx_nxt    = r_idx + 4'd1;
                  w_serial_nxt = w_word_sh[0];
               end
            end
         end
         S_PARITY: begin
            if (w_last) begin
               w_state_nxt  = S_STOP;
               w_serial_nxt = 1'b1;
            end
         end
         S_STOP: begin
            if (w_last) begin
               w_state_nxt  = S_IDLE;
               w_serial_nxt = 1'b1;
               w_done_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 8'd0;
            w_idx_nxt    = 4'd0;
            w_serial_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 8'd0;
         r_idx    <= 4'd0;
         r_word   <= '0;
         r_serial <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_serial <= w_serial_nxt;
         r_done   <= w_done_nxt;
         if (w_load) begin
            r_word <= tx_if.data_in;
         end
      end
   end

   assign tx_if.ready = w_ready;
   assign busy        = ~w_ready;
   assign serial_out  = r_serial;
   assign frame_done  = r_done;
   assign bit_index   = r_idx;

endmodule
`default_nettype wire
